// File: rtl/hdd_phy_discovery_seq_if.sv
// hdd_phy_discovery_seq_if: handshake and result bundle between the discovery sequencer and the ST-506 PHY probe.
interface hdd_phy_discovery_seq_if;
    logic       probe_start;
    logic       probe_done;
    logic       phy_is_differential;
    logic       signal_present;
    logic [7:0] signal_quality;
    logic       termination_ok;

    modport master (
        output probe_start,
        input  probe_done, phy_is_differential, signal_present, signal_quality, termination_ok
    );

    modport slave (
        input  probe_start,
        output probe_done, phy_is_differential, signal_present, signal_quality, termination_ok
    );
endinterface

// File: rtl/hdd_phy_discovery_seq.sv
// hdd_phy_discovery_seq: repeated PHY probe runs with retry/timeout, majority vote SE/diff, PHY configuration.
// Optional macro HDD_PHY_TERM_CONFIRM_EN adds a termination confirmation probe after a differential decision.
module hdd_phy_discovery_seq #(
    parameter int          NUM_RUNS       = 3,
    parameter int          MAX_RETRIES    = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd6_000_000,
    parameter logic [15:0] SETTLE_CYCLES  = 16'd3000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           disc_start,
    input  logic                           disc_abort,
    output logic                           disc_busy,
    output logic                           disc_done,
    output logic [1:0]                     disc_error,
    output logic                           vote_split,
    output logic [2:0]                     runs_valid,
    output logic [7:0]                     result_quality,
    hdd_phy_discovery_seq_if.master        probe,
    output logic                           use_differential,
    output logic                           enable_termination,
    output logic                           term_warn,
    output logic [1:0]                     phy_mode
);
    typedef enum logic [3:0] {
        IDLE, SETTLE, START, WAIT_DONE, ACCUM, DECIDE, DONE, FAIL
`ifdef HDD_PHY_TERM_CONFIRM_EN
        , CONFIRM_SETTLE, CONFIRM_START, CONFIRM_WAIT
`endif
    } state_t;

    state_t      state;
    logic [23:0] timer;
    logic [7:0]  retry_cnt, retry_next, quality_min, cap_quality;
    logic [2:0]  run_idx, diff_votes;
    logic        cap_present, cap_diff;
    logic        in_wait, timed_out, choose_diff, go_fail;
    logic [1:0]  fail_err;

    // Abort, no-signal and retry exhaustion all funnel into one FAIL entry.
    always_comb begin
        in_wait = state == WAIT_DONE;
`ifdef HDD_PHY_TERM_CONFIRM_EN
        in_wait = in_wait || state == CONFIRM_WAIT;
`endif
        retry_next  = retry_cnt + 8'd1;
        timed_out   = in_wait && !probe.probe_done && timer == TIMEOUT_CYCLES - 24'd1;
        choose_diff = {diff_votes, 1'b0} > {1'b0, runs_valid};
        go_fail     = !(state inside {IDLE, DONE, FAIL}) &&
                      (disc_abort || (state == DECIDE && runs_valid == 3'd0) ||
                       (timed_out && retry_next > 8'(MAX_RETRIES)));
        fail_err    = disc_abort ? 2'b11 : (state == DECIDE ? 2'b01 : 2'b10);
    end

    // Sequencer FSM; every output is registered and set on the transition into its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            timer              <= '0;
            retry_cnt          <= '0;
            quality_min        <= '0;
            cap_quality        <= '0;
            run_idx            <= '0;
            diff_votes         <= '0;
            cap_present        <= 1'b0;
            cap_diff           <= 1'b0;
            disc_busy          <= 1'b0;
            disc_done          <= 1'b0;
            disc_error         <= 2'b00;
            vote_split         <= 1'b0;
            runs_valid         <= '0;
            result_quality     <= '0;
            probe.probe_start  <= 1'b0;
            use_differential   <= 1'b0;
            enable_termination <= 1'b0;
`ifdef HDD_PHY_TERM_CONFIRM_EN
            term_warn          <= 1'b0;
`endif
            phy_mode           <= 2'b01;
        end else begin
            probe.probe_start <= 1'b0;
            disc_done         <= 1'b0;
            timer             <= timer + 24'd1;
            if (go_fail) begin
                state              <= FAIL;
                disc_error         <= fail_err;
                disc_done          <= 1'b1;
                disc_busy          <= 1'b0;
                phy_mode           <= 2'b01;
                use_differential   <= 1'b0;
                enable_termination <= 1'b0;
                result_quality     <= '0;
            end else begin
                case (state)
                    IDLE: if (disc_start) begin
                        run_idx            <= '0;
                        retry_cnt          <= '0;
                        runs_valid         <= '0;
                        diff_votes         <= '0;
                        vote_split         <= 1'b0;
                        quality_min        <= 8'hff;
                        phy_mode           <= 2'b00;
                        enable_termination <= 1'b0;
                        disc_busy          <= 1'b1;
                        timer              <= '0;
`ifdef HDD_PHY_TERM_CONFIRM_EN
                        term_warn          <= 1'b0;
`endif
                        state              <= SETTLE;
                    end
                    SETTLE: if (timer == {8'd0, SETTLE_CYCLES}) state <= START;
                    START: begin
                        probe.probe_start <= 1'b1;
                        timer             <= '0;
                        state             <= WAIT_DONE;
                    end
                    WAIT_DONE: if (probe.probe_done) begin
                        cap_present <= probe.signal_present;
                        cap_diff    <= probe.phy_is_differential;
                        cap_quality <= probe.signal_quality;
                        state       <= ACCUM;
                    end else if (timed_out) begin
                        retry_cnt <= retry_next;
                        timer     <= '0;
                        state     <= SETTLE;
                    end
                    ACCUM: begin
                        if (cap_present) begin
                            runs_valid  <= runs_valid + 3'd1;
                            diff_votes  <= diff_votes + {2'b00, cap_diff};
                            quality_min <= cap_quality < quality_min ? cap_quality : quality_min;
                        end
                        run_idx <= run_idx + 3'd1;
                        timer   <= '0;
                        state   <= run_idx + 3'd1 == 3'(NUM_RUNS) ? DECIDE : SETTLE;
                    end
                    DECIDE: begin
                        use_differential   <= choose_diff;
                        enable_termination <= choose_diff;
                        vote_split         <= diff_votes != 3'd0 && diff_votes != runs_valid;
                        phy_mode           <= choose_diff ? 2'b10 : 2'b01;
                        result_quality     <= quality_min;
`ifdef HDD_PHY_TERM_CONFIRM_EN
                        if (choose_diff) begin
                            timer <= '0;
                            state <= CONFIRM_SETTLE;
                        end else
`endif
                        begin
                            state      <= DONE;
                            disc_done  <= 1'b1;
                            disc_busy  <= 1'b0;
                            disc_error <= 2'b00;
                        end
                    end
`ifdef HDD_PHY_TERM_CONFIRM_EN
                    CONFIRM_SETTLE: if (timer == {8'd0, SETTLE_CYCLES}) state <= CONFIRM_START;
                    CONFIRM_START: begin
                        probe.probe_start <= 1'b1;
                        timer             <= '0;
                        state             <= CONFIRM_WAIT;
                    end
                    CONFIRM_WAIT: if (probe.probe_done) begin
                        if (!probe.termination_ok || !probe.signal_present) begin
                            enable_termination <= 1'b0;
                            term_warn          <= 1'b1;
                        end
                        state      <= DONE;
                        disc_done  <= 1'b1;
                        disc_busy  <= 1'b0;
                        disc_error <= 2'b00;
                    end else if (timed_out) begin
                        retry_cnt <= retry_next;
                        timer     <= '0;
                        state     <= CONFIRM_SETTLE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifndef HDD_PHY_TERM_CONFIRM_EN
    assign term_warn = 1'b0;
`endif
endmodule

// File: tb/tb_hdd_phy_discovery_seq.sv
// tb_hdd_phy_discovery_seq: directed discovery runs against a behavioural probe, results checked through a scoreboard.
module tb_hdd_phy_discovery_seq;
`ifdef HDD_PHY_TERM_CONFIRM_EN
    localparam int CONF = 1;
`else
    localparam int CONF = 0;
`endif

    typedef struct {
        logic [1:0] err;
        logic [1:0] mode;
        logic       ud;
        logic       et;
        logic       tw;
        logic [7:0] q;
        logic       vs;
        logic [2:0] rv;
        int         nps;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n, disc_start, disc_abort;
    logic       disc_busy, disc_done, vote_split, use_differential, enable_termination, term_warn;
    logic [1:0] disc_error, phy_mode;
    logic [2:0] runs_valid;
    logic [7:0] result_quality;

    hdd_phy_discovery_seq_if pif ();

    hdd_phy_discovery_seq #(
        .NUM_RUNS(3), .MAX_RETRIES(2), .TIMEOUT_CYCLES(24'd100), .SETTLE_CYCLES(16'd4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .disc_start(disc_start), .disc_abort(disc_abort),
        .disc_busy(disc_busy), .disc_done(disc_done), .disc_error(disc_error),
        .vote_split(vote_split), .runs_valid(runs_valid), .result_quality(result_quality),
        .probe(pif), .use_differential(use_differential), .enable_termination(enable_termination),
        .term_warn(term_warn), .phy_mode(phy_mode)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   errors = 0, checks = 0;
    int   ps_count, ans_idx, silent, abort_at, start_cyc, last_ps_cyc, done_cnt = 0;
    bit   gap_check;
    logic et_at_ps;
    logic [3:0]  tbl_p, tbl_d;
    logic [31:0] tbl_q;
    logic        conf_term;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(logic [1:0] err, logic [1:0] mode, logic ud, logic et, logic tw,
                                logic [7:0] q, logic vs, logic [2:0] rv, int nps);
        exp_t e;
        e.err = err; e.mode = mode; e.ud = ud; e.et = et; e.tw = tw;
        e.q = q; e.vs = vs; e.rv = rv; e.nps = nps;
        return e;
    endfunction

    task automatic load(input logic [3:0] p, input logic [3:0] d, input logic [31:0] q, input logic t);
        tbl_p = p; tbl_d = d; tbl_q = q; conf_term = t;
    endtask

    // Behavioural probe: answers each probe_start after a fixed delay, optionally staying silent or racing an abort.
    initial begin
        forever begin
            @(negedge clk);
            if (pif.probe_start) begin
                ps_count++;
                et_at_ps = enable_termination;
                if (ps_count == 1) check("probe_start_latency", cyc - start_cyc, 6);
                if (gap_check && ps_count > 1) check("timeout_gap_ge_100", 32'(cyc - last_ps_cyc >= 100), 1);
                last_ps_cyc = cyc;
                if (ps_count > silent) begin
                    repeat (10) @(negedge clk);
                    pif.signal_present      = tbl_p[ans_idx];
                    pif.phy_is_differential = tbl_d[ans_idx];
                    pif.signal_quality      = tbl_q[ans_idx*8 +: 8];
                    pif.termination_ok      = conf_term;
                    pif.probe_done          = 1'b1;
                    if (ans_idx == abort_at) disc_abort = 1'b1;
                    ans_idx++;
                    @(negedge clk);
                    pif.probe_done = 1'b0;
                    disc_abort     = 1'b0;
                end
            end
        end
    end

    // Scoreboard consumer: every disc_done pulse pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (disc_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_done: observed=1 expected=0");
                end else begin
                    e = sb.pop_front();
                    check("disc_error", disc_error, e.err);
                    check("phy_mode", phy_mode, e.mode);
                    check("use_differential", use_differential, e.ud);
                    check("enable_termination", enable_termination, e.et);
                    check("term_warn", term_warn, e.tw);
                    check("result_quality", result_quality, e.q);
                    check("vote_split", vote_split, e.vs);
                    check("runs_valid", runs_valid, e.rv);
                    check("probe_starts", ps_count, e.nps);
                    check("busy_at_done", disc_busy, 0);
                end
                done_cnt++;
            end
        end
    end

    task automatic discover(input exp_t e);
        int target;
        target   = done_cnt + 1;
        ps_count = 0;
        ans_idx  = 0;
        sb.push_back(e);
        disc_start = 1'b1;
        start_cyc  = cyc + 1;
        @(negedge clk);
        disc_start = 1'b0;
        check("busy_after_start", disc_busy, 1);
        for (int i = 0; i < 5000 && done_cnt < target; i++) @(negedge clk);
        check("done_within_budget", 32'(done_cnt >= target), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, disc_busy, 0);
        check({tag, "_done"}, disc_done, 0);
        check({tag, "_error"}, disc_error, 0);
        check({tag, "_phy_mode"}, phy_mode, 2'b01);
        check({tag, "_use_diff"}, use_differential, 0);
        check({tag, "_en_term"}, enable_termination, 0);
        check({tag, "_term_warn"}, term_warn, 0);
        check({tag, "_probe_start"}, pif.probe_start, 0);
        check({tag, "_runs_valid"}, runs_valid, 0);
        check({tag, "_quality"}, result_quality, 0);
        check({tag, "_vote_split"}, vote_split, 0);
    endtask

    initial begin
        reset_n = 1'b0; disc_start = 1'b0; disc_abort = 1'b0;
        pif.probe_done = 1'b0; pif.signal_present = 1'b0; pif.phy_is_differential = 1'b0;
        pif.signal_quality = 8'd0; pif.termination_ok = 1'b0;
        silent = 0; abort_at = -1; gap_check = 1'b0; ps_count = 0; ans_idx = 0;
        start_cyc = 0; last_ps_cyc = 0; et_at_ps = 1'b0;
        load(4'b0000, 4'b0000, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(negedge clk);

        load(4'b1111, 4'b0000, 32'h00dc_c8ff, 1'b1);
        discover(mk(2'b00, 2'b01, 0, 0, 0, 8'd200, 0, 3'd3, 3));

        load(4'b1111, 4'b1011, 32'h011e_140a, 1'b1);
        discover(mk(2'b00, 2'b10, 1, 1, 0, 8'd10, 1, 3'd3, 3 + CONF));

        load(4'b1011, 4'b1001, 32'h0005_2832, 1'b1);
        discover(mk(2'b00, 2'b01, 0, 0, 0, 8'd40, 1, 3'd2, 3));

        load(4'b1000, 4'b0111, 32'h0009_0909, 1'b1);
        discover(mk(2'b01, 2'b01, 0, 0, 0, 8'd0, 0, 3'd0, 3));

        silent = 99; gap_check = 1'b1;
        discover(mk(2'b10, 2'b01, 0, 0, 0, 8'd0, 0, 3'd0, 3));
        gap_check = 1'b0;

        silent = 1;
        load(4'b1111, 4'b0000, 32'h0050_5a64, 1'b1);
        discover(mk(2'b00, 2'b01, 0, 0, 0, 8'd80, 0, 3'd3, 4));
        silent = 0;

        abort_at = 1;
        load(4'b1111, 4'b0000, 32'h0030_4046, 1'b1);
        discover(mk(2'b11, 2'b01, 0, 0, 0, 8'd0, 0, 3'd1, 2));
        abort_at = -1;
        repeat (30) @(negedge clk);
        check("no_probe_after_abort", ps_count, 2);

`ifdef HDD_PHY_TERM_CONFIRM_EN
        load(4'b1111, 4'b1111, 32'h0007_0809, 1'b0);
        discover(mk(2'b00, 2'b10, 1, 0, 1, 8'd7, 0, 3'd3, 4));
        check("en_term_at_confirm_probe", et_at_ps, 1);

        load(4'b1111, 4'b1111, 32'h0007_0809, 1'b1);
        discover(mk(2'b00, 2'b10, 1, 1, 0, 8'd7, 0, 3'd3, 4));
        check("en_term_at_confirm_probe_ok", et_at_ps, 1);
`endif

        load(4'b1111, 4'b1111, 32'h0011_2233, 1'b1);
        ps_count = 0;
        disc_start = 1'b1;
        start_cyc  = cyc + 1;
        @(negedge clk);
        disc_start = 1'b0;
        @(negedge clk);
        check("settle_phy_mode_off", phy_mode, 2'b00);
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_probe_after_reset", ps_count, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
